// File: rtl/wbu_pkg.sv
// Shared definitions for the Wishbone-over-UART write-value compressor and its decompressor.
// Key extraction and codeword packing must stay identical on both ends.
package wbu_pkg;

  localparam logic [2:0] WBU_WR_RAW = 3'b011;
  localparam logic [2:0] WBU_WR_TBL = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_EMIT
  } wbu_state_t;

  function automatic logic wbu_is_wr(input logic [35:0] w);
    return w[35:33] == WBU_WR_RAW;
  endfunction

  // Bit 30 is the address-increment flag; it travels in the codeword, not the table.
  function automatic logic [31:0] wbu_key(input logic [35:0] w);
    return {w[32:31], w[29:0]};
  endfunction

  function automatic logic [35:0] wbu_pack_tbl(input logic [7:0] d, input logic inc);
    return {WBU_WR_TBL, d[7:6], inc, d[5:0], 24'h0};
  endfunction

endpackage

// File: rtl/wbu_histram.sv
// 256x32 write-value history: one synchronous write port, one registered read port.
module wbu_histram (
  input  logic        i_clk,
  input  logic        we,
  input  logic [7:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [7:0]  raddr,
  output logic [31:0] rdata
);

  logic [31:0] mem [0:255];

  // No reset on purpose, so the array maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (we)
      mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/wbu_wr_compress.sv
// Host-side write-value compressor: replaces repeated write values with
// backward table references into a 256-entry history shared with the decompressor.
import wbu_pkg::*;

// state     | meaning
// ST_IDLE   | ready, o_busy low, waiting for a word
// ST_SEARCH | walking history backwards, one read per clock
// ST_EMIT   | output word valid, waiting for downstream
module wbu_wr_compress #(
  parameter int unsigned SEARCH_MAX = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stb,
  input  logic [35:0] i_word,
  output logic        o_busy,
  output logic        o_stb,
  output logic [35:0] o_word,
  input  logic        i_busy
);

  localparam logic [7:0] SMAX = 8'(SEARCH_MAX);

  wbu_state_t  state;
  logic [7:0]  wr_ptr;
  logic [7:0]  cnt;
  logic [7:0]  lim;
  logic [35:0] word_q;
  logic [31:0] key_q;
  logic [7:0]  rd_d;
  logic        cmp_vld;

  logic        accept;
  logic        in_wr;
  logic [7:0]  lim_now;
  logic [7:0]  cmp_d;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic        hit;
  logic        miss_end;
  logic        hist_we;
  logic [31:0] hist_wdata;

  assign accept  = i_stb && !o_busy;
  assign in_wr   = wbu_is_wr(i_word);
  assign lim_now = (cnt < SMAX) ? cnt : SMAX;

  // rd_d is the distance of the read issued now; the data on rd_data is one behind.
  // Both wrap at 8 bits, which lands cmp_d on 255 exactly when needed.
  assign rd_addr  = wr_ptr - rd_d;
  assign cmp_d    = rd_d - 8'd1;
  assign hit      = (state == ST_SEARCH) && cmp_vld && (rd_data == key_q);
  assign miss_end = (state == ST_SEARCH) && cmp_vld && !hit && (cmp_d == lim);

  assign hist_we    = (accept && in_wr && (lim_now == 8'd0)) || miss_end;
  assign hist_wdata = (state == ST_SEARCH) ? key_q : wbu_key(i_word);

  wbu_histram u_hist (
    .i_clk (i_clk),
    .we    (hist_we),
    .waddr (wr_ptr),
    .wdata (hist_wdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      o_stb   <= 1'b0;
      o_busy  <= 1'b0;
      o_word  <= '0;
      wr_ptr  <= '0;
      cnt     <= '0;
      lim     <= '0;
      word_q  <= '0;
      key_q   <= '0;
      rd_d    <= '0;
      cmp_vld <= 1'b0;
    end else begin
      if (hist_we) begin
        wr_ptr <= wr_ptr + 8'd1;
        if (cnt != 8'hff)
          cnt <= cnt + 8'd1;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            word_q  <= i_word;
            key_q   <= wbu_key(i_word);
            lim     <= lim_now;
            rd_d    <= 8'd1;
            cmp_vld <= 1'b0;
            o_busy  <= 1'b1;
            if (in_wr && (lim_now != 8'd0)) begin
              state <= ST_SEARCH;
            end else begin
              state  <= ST_EMIT;
              o_stb  <= 1'b1;
              o_word <= i_word;
            end
          end
        end
        ST_SEARCH: begin
          rd_d    <= rd_d + 8'd1;
          cmp_vld <= 1'b1;
          if (hit) begin
            state  <= ST_EMIT;
            o_stb  <= 1'b1;
            o_word <= wbu_pack_tbl(cmp_d, word_q[30]);
          end else if (miss_end) begin
            state  <= ST_EMIT;
            o_stb  <= 1'b1;
            o_word <= word_q;
          end
        end
        ST_EMIT: begin
          if (!i_busy) begin
            state  <= ST_IDLE;
            o_stb  <= 1'b0;
            o_busy <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
